// File: rtl/serial_sub_pkg.sv
// Shared state encoding and sizing helper for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Counter width; a floor of 1 keeps the declaration legal for tiny widths.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/fs_cell.sv
// Single-bit full subtractor: d = a - b - bi, borrow out on bo.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bi, LSB first, through one fs_cell and a borrow flop,
// wrapped in a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one bit per clock, WIDTH cycles
// DONE  | one-cycle done pulse; start here chains straight into RUN
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             ov
);

   localparam int CNT_W = cnt_w(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sa_d;
   logic [WIDTH-1:0]   sb_q, sb_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               br_q, br_d;
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               bo_q, bo_d;
   logic               ov_q, ov_d;

   logic               cell_d;
   logic               cell_bo;
   logic [WIDTH-1:0]   sr_shift;
   logic               load;

   fs_cell u_cell (
      .a  (sa_q[0]),
      .b  (sb_q[0]),
      .bi (br_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   assign sr_shift = {cell_d, sr_q[WIDTH-1:1]};
   assign load     = start && ((state_q == IDLE) || (state_q == DONE));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      d_d     = d_q;
      bo_d    = bo_q;
      ov_d    = ov_q;

      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            sa_d = {1'b0, sa_q[WIDTH-1:1]};
            sb_d = {1'b0, sb_q[WIDTH-1:1]};
            sr_d = sr_shift;
            br_d = cell_bo;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               cnt_d   = '0;
               d_d     = sr_shift;
               bo_d    = cell_bo;
               // Overflow only when operand signs differ and the result sign flips away from a.
               ov_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = start ? RUN : IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         sa_d    = a;
         sb_d    = b;
         br_d    = bi;
         cnt_d   = '0;
         sr_d    = '0;
         a_msb_d = a[WIDTH-1];
         b_msb_d = b[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         d_q     <= '0;
         bo_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         d_q     <= d_d;
         bo_q    <= bo_d;
         ov_q    <= ov_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign d    = d_q;
   assign bo   = bo_q;
   assign ov   = ov_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): cell table, directed vectors,
// handshake/reset sequences and randomized operands against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic bi;
      logic a;
      logic b;
      logic d;
      logic bo;
   } cell_vec_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } op_vec_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bi;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bo;
   logic         ov;

   logic         c_a, c_b, c_bi, c_d, c_bo;

   int n_vec = 0;
   int n_bad = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bi    (bi),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bo    (bo),
      .ov    (ov)
   );

   fs_cell u_cell_tb (
      .a  (c_a),
      .b  (c_b),
      .bi (c_bi),
      .d  (c_d),
      .bo (c_bo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: unsigned wrap, borrow as a<b+bi, signed range overflow.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi,
                        output logic [W-1:0] ed, output logic ebo, output logic eov);
      int diff, sa, sb, sd;
      diff = int'(ma) - int'(mb) - int'(mbi);
      ed   = diff[W-1:0];
      ebo  = (diff < 0);
      sa   = (int'(ma) >= 128) ? int'(ma) - 256 : int'(ma);
      sb   = (int'(mb) >= 128) ? int'(mb) - 256 : int'(mb);
      sd   = sa - sb - int'(mbi);
      eov  = (sd < -128) || (sd > 127);
   endtask

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic start_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbi);
      a     = xa;
      b     = xb;
      bi    = xbi;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int nbusy, output bit seen, output bit held);
      logic [W-1:0] d0;
      logic         bo0, ov0;
      d0 = d; bo0 = bo; ov0 = ov;
      nbusy = 0; seen = 1'b0; held = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) nbusy++;
            if (d !== d0 || bo !== bo0 || ov !== ov0) held = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xbi, input logic [W-1:0] ed, input logic ebo, input logic eov);
      int nb;
      bit seen, held;
      start_op(xa, xb, xbi);
      wait_done(nb, seen, held);
      check({name, " done_seen"}, 32'(seen), 32'd1);
      check({name, " busy_cycles"}, 32'(nb), 32'(W));
      check({name, " hold_during_run"}, 32'(held), 32'd1);
      check({name, " d"}, 32'(d), 32'(ed));
      check({name, " bo"}, 32'(bo), 32'(ebo));
      check({name, " ov"}, 32'(ov), 32'(eov));
      @(negedge clk);
      check({name, " done_one_cycle"}, {30'd0, done, busy}, 32'd0);
   endtask

   cell_vec_t cell_tab [8];
   op_vec_t   op_tab [5];

   initial begin
      logic [7:0] td, tbo;
      int  nb;
      bit  seen, held, quiet;
      logic [W-1:0] ra, rb, ed;
      logic rbi, ebo, eov;

      td  = 8'b1001_0110;
      tbo = 8'b1011_0010;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] idx;
         idx = 3'(i);
         cell_tab[i] = '{bi: idx[2], a: idx[1], b: idx[0], d: td[i], bo: tbo[i]};
      end
      op_tab[0] = '{a: 8'h05, b: 8'h03, bi: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
      op_tab[1] = '{a: 8'h03, b: 8'h05, bi: 1'b0, d: 8'hFE, bo: 1'b1, ov: 1'b0};
      op_tab[2] = '{a: 8'h00, b: 8'h00, bi: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
      op_tab[3] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
      op_tab[4] = '{a: 8'h00, b: 8'h01, bi: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
      c_a = 1'b0; c_b = 1'b0; c_bi = 1'b0;

      for (int i = 0; i < 8; i++) begin
         c_bi = cell_tab[i].bi; c_a = cell_tab[i].a; c_b = cell_tab[i].b;
         #1;
         check($sformatf("cell%0d d", i), 32'(c_d), 32'(cell_tab[i].d));
         check($sformatf("cell%0d bo", i), 32'(c_bo), 32'(cell_tab[i].bo));
      end

      repeat (2) @(negedge clk);
      check("reset outputs", {21'd0, busy, done, d, bo, ov}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_op($sformatf("vec%0d", i), op_tab[i].a, op_tab[i].b, op_tab[i].bi,
                op_tab[i].d, op_tab[i].bo, op_tab[i].ov);

      // start pulsed mid-run must be ignored
      start_op(8'h05, 8'h03, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(nb, seen, held);
      check("ignore done_seen", 32'(seen), 32'd1);
      check("ignore busy_cycles", 32'(nb), 32'(W - 3));
      check("ignore d", 32'(d), 32'h02);
      @(negedge clk);
      check("ignore no_restart", {30'd0, busy, done}, 32'd0);

      // start held during DONE chains a new run immediately
      start_op(8'h05, 8'h03, 1'b0);
      wait_done(nb, seen, held);
      check("b2b first d", 32'(d), 32'h02);
      start_op(8'h10, 8'h01, 1'b0);
      check("b2b busy_immediate", 32'(busy), 32'd1);
      wait_done(nb, seen, held);
      check("b2b done_seen", 32'(seen), 32'd1);
      check("b2b busy_cycles", 32'(nb), 32'(W));
      check("b2b d", 32'(d), 32'h0F);
      @(negedge clk);

      // asynchronous reset mid-run
      start_op(8'h05, 8'h03, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst busy/done/d/bo/ov", {21'd0, busy, done, d, bo, ov}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (done || busy) quiet = 1'b0;
         @(negedge clk);
      end
      check("rst no_done_after", 32'(quiet), 32'd1);
      run_op("post_rst", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         ra  = W'($urandom_range(0, 255));
         rb  = W'($urandom_range(0, 255));
         rbi = 1'($urandom_range(0, 1));
         if (i == 0) begin ra = 8'h7F; rb = 8'h80; rbi = 1'b0; end
         if (i == 1) begin ra = 8'h80; rb = 8'h00; rbi = 1'b1; end
         model(ra, rb, rbi, ed, ebo, eov);
         run_op($sformatf("rand%0d", i), ra, rb, rbi, ed, ebo, eov);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
